// File: rtl/bcd_set_register.sv
// bcd_set_register: one two-digit BCD setting field with edit/commit/cancel.
// Ports: Clk, Reset (async, active-low), editPulse, cancelPulse, upPulse,
//   downPulse, extLoad, extValue[7:0] in; value[7:0], committed[7:0],
//   editing, commitStrobe out. Optional idle-edit timeout: BCD_SET_TIMEOUT_EN.
module bcd_set_register #(
  parameter int MAX_VALUE      = 59,
  parameter int MIN_VALUE      = 0,
  parameter int INIT_VALUE     = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       editPulse,
  input  logic       cancelPulse,
  input  logic       upPulse,
  input  logic       downPulse,
  input  logic       extLoad,
  input  logic [7:0] extValue,
  output logic [7:0] value,
  output logic [7:0] committed,
  output logic       editing,
  output logic       commitStrobe
);

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  localparam logic [7:0] MAX_BCD  = to_bcd(MAX_VALUE);
  localparam logic [7:0] MIN_BCD  = to_bcd(MIN_VALUE);
  localparam logic [7:0] INIT_BCD = to_bcd(INIT_VALUE);

  typedef enum logic {IDLE, EDIT} state_t;

  state_t     state, state_n;
  logic [7:0] working, working_n;
  logic [7:0] committed_n, value_n;
  logic       editing_n, strobe_n;
  logic       commit;
  logic       expire;
  logic       ext_ok;
  logic [8:0] lo_diff, hi_diff;

  // Valid BCD bytes order the same as their decimal values, so the
  // range check can be done directly on the BCD encoding.
  assign lo_diff = {1'b0, extValue} - {1'b0, MIN_BCD};
  assign hi_diff = {1'b0, MAX_BCD} - {1'b0, extValue};
  assign ext_ok  = (extValue[7:4] <= 4'd9) && (extValue[3:0] <= 4'd9)
                && !lo_diff[8] && !hi_diff[8];

`ifdef BCD_SET_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt, tmo_n;
  logic          any_pulse;

  assign any_pulse = editPulse | cancelPulse | upPulse | downPulse;
  assign expire    = (state == EDIT) && (tmo_cnt == TMO_LAST);

  always_comb begin
    tmo_n = '0;
    if (state == EDIT && state_n == EDIT && !any_pulse)
      tmo_n = tmo_cnt + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) tmo_cnt <= '0;
    else        tmo_cnt <= tmo_n;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    working_n   = working;
    committed_n = committed;
    strobe_n    = 1'b0;
    commit      = 1'b0;
    unique case (state)
      IDLE: begin
        if (editPulse) begin
          state_n   = EDIT;
          working_n = committed;
        end
      end
      EDIT: begin
        if (cancelPulse || expire) begin
          state_n = IDLE;
        end else if (editPulse) begin
          committed_n = working;
          strobe_n    = 1'b1;
          commit      = 1'b1;
          state_n     = IDLE;
        end else if (upPulse && !downPulse) begin
          working_n = (working == MAX_BCD) ? MIN_BCD : bcd_inc(working);
        end else if (downPulse && !upPulse) begin
          working_n = (working == MIN_BCD) ? MAX_BCD : bcd_dec(working);
        end
      end
      default: state_n = IDLE;
    endcase
    // A commit on the same edge takes precedence over an external load.
    if (extLoad && ext_ok && !commit)
      committed_n = extValue;
    editing_n = (state_n == EDIT);
    value_n   = editing_n ? working_n : committed_n;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      working      <= INIT_BCD;
      committed    <= INIT_BCD;
      value        <= INIT_BCD;
      editing      <= 1'b0;
      commitStrobe <= 1'b0;
    end else begin
      state        <= state_n;
      working      <= working_n;
      committed    <= committed_n;
      value        <= value_n;
      editing      <= editing_n;
      commitStrobe <= strobe_n;
    end
  end

endmodule

// File: tb/tb_bcd_set_register.sv
// tb_bcd_set_register: directed + random stimulus against a decimal model.
// Checks value/committed/editing/commitStrobe after every clock edge.
module tb_bcd_set_register;

  localparam int MAXV = 59;
  localparam int MINV = 0;
  localparam int INIT = 0;
  localparam int TMO  = 16;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       editPulse = 1'b0;
  logic       cancelPulse = 1'b0;
  logic       upPulse = 1'b0;
  logic       downPulse = 1'b0;
  logic       extLoad = 1'b0;
  logic [7:0] extValue = 8'h00;
  logic [7:0] value, committed;
  logic       editing, commitStrobe;

  int errors = 0;
  int checks = 0;

  // decimal model state
  bit m_edit;
  int m_work, m_comm, m_cnt;
  bit m_strobe;

  bcd_set_register #(
    .MAX_VALUE(MAXV), .MIN_VALUE(MINV),
    .INIT_VALUE(INIT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .editPulse(editPulse), .cancelPulse(cancelPulse),
    .upPulse(upPulse), .downPulse(downPulse),
    .extLoad(extLoad), .extValue(extValue),
    .value(value), .committed(committed),
    .editing(editing), .commitStrobe(commitStrobe)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] bcd(input int d);
    logic [7:0] r;
    r[7:4] = 4'(d / 10);
    r[3:0] = 4'(d % 10);
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edit = 0; m_work = INIT; m_comm = INIT;
    m_cnt = 0; m_strobe = 0;
  endtask

  task automatic model_step(input bit e, c, u, d, l,
                            input logic [7:0] x);
    bit commit, expire, was_edit;
    int t, n;
    commit = 0;
    m_strobe = 0;
    was_edit = m_edit;
    expire = 0;
`ifdef BCD_SET_TIMEOUT_EN
    expire = m_edit && (m_cnt == TMO - 1);
`endif
    if (m_edit) begin
      if (c || expire) m_edit = 0;
      else if (e) begin
        m_comm = m_work; m_strobe = 1; commit = 1; m_edit = 0;
      end else if (u && !d)
        m_work = (m_work == MAXV) ? MINV : m_work + 1;
      else if (d && !u)
        m_work = (m_work == MINV) ? MAXV : m_work - 1;
    end else if (e) begin
      m_edit = 1;
      m_work = m_comm;
    end
    t = int'(x[7:4]);
    n = int'(x[3:0]);
    if (l && !commit && t <= 9 && n <= 9
        && t * 10 + n >= MINV && t * 10 + n <= MAXV)
      m_comm = t * 10 + n;
    if (was_edit && m_edit && !(e || c || u || d)) m_cnt++;
    else m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".value"}, value, bcd(m_edit ? m_work : m_comm));
    check({tag, ".committed"}, committed, bcd(m_comm));
    check({tag, ".editing"}, {7'd0, editing}, {7'd0, m_edit});
    check({tag, ".strobe"}, {7'd0, commitStrobe}, {7'd0, m_strobe});
  endtask

  // drive at negedge, clock, then sample at the following negedge
  task automatic cyc(input string tag, input bit e, c, u, d, l,
                     input logic [7:0] x);
    editPulse = e; cancelPulse = c; upPulse = u; downPulse = d;
    extLoad = l; extValue = x;
    @(posedge Clk);
    model_step(e, c, u, d, l, x);
    @(negedge Clk);
    editPulse = 0; cancelPulse = 0; upPulse = 0; downPulse = 0;
    extLoad = 0;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge Clk);
    Reset = 1'b1;
    idle("post_reset");

    // async reset mid-EDIT with working = 37
    cyc("ld37", 0, 0, 0, 0, 1, 8'h37);
    cyc("edit37", 1, 0, 0, 0, 0, 8'h00);
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge Clk);
    Reset = 1'b1;
    idle("rst_rel");

    // wrap up through MAX and commit
    cyc("ld57", 0, 0, 0, 0, 1, 8'h57);
    cyc("enter", 1, 0, 0, 0, 0, 8'h00);
    cyc("up58", 0, 0, 1, 0, 0, 8'h00);
    cyc("up59", 0, 0, 1, 0, 0, 8'h00);
    cyc("upwrap", 0, 0, 1, 0, 0, 8'h00);
    cyc("commit0", 1, 0, 0, 0, 0, 8'h00);
    idle("strobe_off");

    // down wrap, up+down, cancel
    cyc("ld57b", 0, 0, 0, 0, 1, 8'h57);
    cyc("enter2", 1, 0, 0, 0, 0, 8'h00);
    cyc("up58b", 0, 0, 1, 0, 0, 8'h00);
    cyc("up59b", 0, 0, 1, 0, 0, 8'h00);
    cyc("up00b", 0, 0, 1, 0, 0, 8'h00);
    cyc("dnwrap", 0, 0, 0, 1, 0, 8'h00);
    cyc("updn", 0, 0, 1, 1, 0, 8'h00);
    cyc("cancel", 0, 1, 0, 0, 0, 8'h00);

    // external loads
    cyc("ld4A", 0, 0, 0, 0, 1, 8'h4A);
    cyc("ld61", 0, 0, 0, 0, 1, 8'h61);
    cyc("ld42", 0, 0, 0, 0, 1, 8'h42);
    cyc("ld20", 0, 0, 0, 0, 1, 8'h20);
    cyc("enter3", 1, 0, 0, 0, 0, 8'h00);
    cyc("ld13e", 0, 0, 0, 0, 1, 8'h13);
    cyc("commit20", 1, 0, 0, 0, 0, 8'h00);
    cyc("enter4", 1, 0, 0, 0, 0, 8'h00);
    cyc("cmt_ld", 1, 0, 0, 0, 1, 8'h33);

    // edit+cancel, edit+up
    cyc("enter5", 1, 0, 0, 0, 0, 8'h00);
    cyc("ed_can", 1, 1, 0, 0, 0, 8'h00);
    cyc("ld09", 0, 0, 0, 0, 1, 8'h09);
    cyc("enter6", 1, 0, 0, 0, 0, 8'h00);
    cyc("ed_up", 1, 0, 1, 0, 0, 8'h00);
    idle("after_edup");

`ifdef BCD_SET_TIMEOUT_EN
    cyc("tmo_enter", 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) idle("tmo_wait");
    cyc("tmo_up", 0, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 20; i++) idle("tmo_run");
`endif

    // random traffic
    for (int i = 0; i < 800; i++) begin
      bit e, c, u, d, l;
      logic [7:0] x;
      e = ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 11) == 0);
      u = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) x = bcd($urandom_range(0, 99));
      else x = 8'($urandom_range(0, 255));
      cyc("rand", e, c, u, d, l, x);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
